i2s_frame_master: RTL and testbench
===================================

Name: i2s_frame_master

Overview:
- Generates I2S bit clock (SCLK) and PCM Format A frame sync (LRCLK) from the system clock.
- Accepts stereo samples from the SID core over a valid/ready handshake and presents them as a frame word on audio_o.
- Sits directly upstream of the I2S DSP-mode serializer, driving its i2s_sclk, i2s_lrclk and audio_o inputs.

Parameters:
- BITS, 24, bits per channel sample.
- CHANNELS, 2, channels per frame; audio_o width is CHANNELS*BITS.
- SCLK_DIV, 4, clk cycles per SCLK half-period; must be ≥4.
- FRAME_BITS, 64, SCLK periods per frame; must be ≥ CHANNELS*BITS+1.
- MUTE_ON_UNDERRUN, 0, 1 = send zero frame on underrun; 0 = repeat last frame.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run SCLK/LRCLK; low = idle.
- sample_i  in  CHANNELS*BITS  channel 0 in MSBs, signed per channel.
- sample_valid_i  in  1  sample_i valid.
- sample_ready_o  out  1  holding register empty.
- i2s_sclk  out  1  bit clock.
- i2s_lrclk  out  1  frame sync, high for one SCLK period.
- audio_o  out  CHANNELS*BITS  frame word to serializer.
- frame_start_o  out  1  one-clk pulse when LRCLK rises.
- underrun_o  out  1  one-clk pulse: frame boundary with no sample held.
- underrun_count  out  16  saturating underrun count.

Behaviour:
- Reset values: i2s_sclk=0, i2s_lrclk=0, audio_o=0, frame_start_o=0, underrun_o=0, underrun_count=0, sample_ready_o=1, holding empty, div_cnt=0, bit_cnt=FRAME_BITS-1.
- Divider: div_cnt counts 0..SCLK_DIV-1. At SCLK_DIV-1 it wraps and i2s_sclk toggles. All outputs are registered.
- SCLK falling toggle: bit_cnt increments modulo FRAME_BITS.
- SCLK rising toggle: i2s_lrclk <= (bit_cnt==FRAME_BITS-1). LRCLK therefore changes only on rising edges and is stable at every falling edge.
- Frame boundary: the rising toggle that sets i2s_lrclk=1. In that same clk:
  - frame_start_o pulses.
  - If holding is full: audio_o <= holding and holding empties.
  - Else: audio_o <= 0 if MUTE_ON_UNDERRUN, else unchanged; underrun_o pulses; underrun_count increments, saturating at 0xFFFF.
- audio_o is constant from one frame boundary to the next. It is therefore stable ≥SCLK_DIV clk before the falling edge at which the serializer loads it, which covers the serializer's 3-clk sync/edge-detect delay.
- Handshake:
  - sample_ready_o = ~holding_full, registered.
  - Transfer occurs when sample_valid_i & sample_ready_o; holding loads and sample_ready_o drops next clk.
  - Transfer and frame-boundary drain never coincide: ready is low whenever holding is full. A drained holding reasserts ready the following clk.
  - sample_i is ignored while ready is low.
- Enable:
  - enable=0 holds i2s_sclk=0 and i2s_lrclk=0, clears div_cnt, sets bit_cnt=FRAME_BITS-1. Holding, audio_o and underrun_count are retained, and the handshake stays live.
  - enable 0→1: the first rising toggle (after SCLK_DIV clk) is a frame boundary.
  - enable dropping mid-frame aborts immediately; no partial-frame state persists.
- Reset mid-operation returns everything to reset values asynchronously; release is synchronous to clk.
- Frame period = 2*SCLK_DIV*FRAME_BITS clk.
- Illegal parameter values (SCLK_DIV<4, FRAME_BITS<CHANNELS*BITS+1) raise an elaboration-time error.

Decomposition:
- Shared package i2s_pkg: localparams for default BITS/CHANNELS/FRAME_BITS, and a typedef for the packed stereo frame (struct of CHANNELS signed [BITS-1:0] fields).
- Sub-module i2s_clkdiv: divider plus bit counter producing sclk, lrclk and the one-clk rise/fall/frame_boundary strobes.
- The top level holds the handshake, holding register and underrun logic.

Test Plan:
- Reset then enable=1, BITS=16, CHANNELS=2, SCLK_DIV=4, FRAME_BITS=64 -> SCLK period 8 clk; LRCLK high for exactly 8 clk every 512 clk; frame_start_o once per 512 clk.
- Present 0x1234_ABCD before first boundary -> ready drops 1 clk after accept; audio_o=0x1234ABCD at first frame_start_o; ready=1 next clk; no underrun.
- No new sample for the second frame, MUTE_ON_UNDERRUN=0 -> audio_o stays 0x1234ABCD, underrun_o pulses, underrun_count=1. With MUTE_ON_UNDERRUN=1 -> audio_o=0.
- Hold valid high with incrementing data over 3 frames -> exactly one sample consumed per frame, in order, and no beat accepted while ready=0.
- Drop enable mid-frame for 100 clk, then re-raise -> sclk/lrclk low while disabled; first frame_start_o occurs SCLK_DIV clk after re-enable; held sample is preserved.
- Force 70000 underruns -> underrun_count saturates at 0xFFFF. Assert rst_n=0 mid-frame -> all outputs zero immediately, ready=1.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S frame master.
//   - Default sizing for samples, channels, divider and frame length.
//   - Width of the saturating underrun counter.
//   - Packed stereo frame type: channel 0 occupies the MSBs, matching audio_o.
package i2s_pkg;

  localparam int unsigned DEF_BITS       = 24;
  localparam int unsigned DEF_CHANNELS   = 2;
  localparam int unsigned DEF_SCLK_DIV   = 4;
  localparam int unsigned DEF_FRAME_BITS = 64;
  localparam int unsigned CNT_W          = 16;

  typedef struct packed {
    logic signed [DEF_BITS-1:0] ch0;
    logic signed [DEF_BITS-1:0] ch1;
  } stereo_frame_t;

endpackage

// File: rtl/i2s_clkdiv.sv
// I2S bit clock divider and frame bit counter.
//
// Ports
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   enable_i         run the divider; low forces SCLK/LRCLK low and rearms the frame
//   sclk_o           registered bit clock
//   lrclk_o          registered frame sync, high for one SCLK period per frame
//   rise_o           one-clk strobe: SCLK toggles 0->1 on the coming edge
//   fall_o           one-clk strobe: SCLK toggles 1->0 on the coming edge
//   frame_boundary_o one-clk strobe: the coming rising toggle raises LRCLK
//
// The strobes are combinational and coincide with the clk edge that updates
// sclk_o/lrclk_o, so a consumer registering on a strobe changes its outputs in
// the same cycle the clocks change.
module i2s_clkdiv
  import i2s_pkg::*;
#(
  parameter int unsigned SCLK_DIV   = DEF_SCLK_DIV,
  parameter int unsigned FRAME_BITS = DEF_FRAME_BITS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  output logic sclk_o,
  output logic lrclk_o,
  output logic rise_o,
  output logic fall_o,
  output logic frame_boundary_o
);

  localparam int unsigned DIV_W = $clog2(SCLK_DIV);
  localparam int unsigned BIT_W = $clog2(FRAME_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             sclk_q, sclk_d;
  logic             lrclk_q, lrclk_d;
  logic             wrap;

  always_comb begin
    wrap    = enable_i && (div_q == DIV_LAST);
    div_d   = div_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    lrclk_d = lrclk_q;
    if (!enable_i) begin
      // Idle: bit counter parked on the last bit so the first rising
      // toggle after enable is a frame boundary.
      div_d   = '0;
      bit_d   = BIT_LAST;
      sclk_d  = 1'b0;
      lrclk_d = 1'b0;
    end else if (wrap) begin
      div_d  = '0;
      sclk_d = ~sclk_q;
      if (!sclk_q) begin
        // LRCLK only moves on rising toggles, so it is stable at every falling edge.
        lrclk_d = (bit_q == BIT_LAST);
      end else begin
        bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
      end
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      bit_q   <= BIT_LAST;
      sclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      lrclk_q <= lrclk_d;
    end
  end

  assign sclk_o           = sclk_q;
  assign lrclk_o          = lrclk_q;
  assign rise_o           = wrap & ~sclk_q;
  assign fall_o           = wrap & sclk_q;
  assign frame_boundary_o = wrap & ~sclk_q & (bit_q == BIT_LAST);

endmodule

// File: rtl/i2s_frame_master.sv
// I2S frame master: generates SCLK and a PCM Format A frame sync, accepts
// stereo samples over valid/ready into a one-entry holding register and
// presents one frame word per frame to the downstream DSP-mode serializer.
//
// Ports
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   enable          run SCLK/LRCLK; low = idle (handshake stays live)
//   sample_i        CHANNELS*BITS sample, channel 0 in MSBs
//   sample_valid_i  sample_i valid
//   sample_ready_o  holding register empty (registered)
//   i2s_sclk        bit clock
//   i2s_lrclk       frame sync, high for one SCLK period
//   audio_o         frame word, constant between frame boundaries
//   frame_start_o   one-clk pulse when LRCLK rises
//   underrun_o      one-clk pulse: frame boundary with nothing held
//   underrun_count  saturating count of underruns
module i2s_frame_master
  import i2s_pkg::*;
#(
  parameter int unsigned BITS             = DEF_BITS,
  parameter int unsigned CHANNELS         = DEF_CHANNELS,
  parameter int unsigned SCLK_DIV         = DEF_SCLK_DIV,
  parameter int unsigned FRAME_BITS       = DEF_FRAME_BITS,
  parameter bit          MUTE_ON_UNDERRUN = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [CHANNELS*BITS-1:0] sample_i,
  input  logic                     sample_valid_i,
  output logic                     sample_ready_o,
  output logic                     i2s_sclk,
  output logic                     i2s_lrclk,
  output logic [CHANNELS*BITS-1:0] audio_o,
  output logic                     frame_start_o,
  output logic                     underrun_o,
  output logic [CNT_W-1:0]         underrun_count
);

  localparam int unsigned W = CHANNELS * BITS;

  if (SCLK_DIV < 4) begin : g_bad_sclk_div
    $error("i2s_frame_master: SCLK_DIV must be at least 4");
  end
  if (FRAME_BITS < W + 1) begin : g_bad_frame_bits
    $error("i2s_frame_master: FRAME_BITS must be at least CHANNELS*BITS+1");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic             sclk, lrclk, sclk_rise, sclk_fall, boundary;
  logic             accept;
  logic [W-1:0]     hold_q, hold_d;
  logic [W-1:0]     audio_q, audio_d;
  logic             full_q, full_d;
  logic             ready_q, ready_d;
  logic             fs_q, fs_d;
  logic             ur_q, ur_d;
  logic [CNT_W-1:0] underrun_cnt_q, underrun_cnt_d;

  i2s_clkdiv #(
    .SCLK_DIV   (SCLK_DIV),
    .FRAME_BITS (FRAME_BITS)
  ) u_clkdiv (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable_i         (enable),
    .sclk_o           (sclk),
    .lrclk_o          (lrclk),
    .rise_o           (sclk_rise),
    .fall_o           (sclk_fall),
    .frame_boundary_o (boundary)
  );

  // Only the frame boundary strobe matters at this level.
  logic unused_edge_strobes;
  assign unused_edge_strobes = sclk_rise ^ sclk_fall;

  always_comb begin
    accept         = sample_valid_i & ready_q;
    hold_d         = hold_q;
    full_d         = full_q;
    audio_d        = audio_q;
    fs_d           = boundary;
    ur_d           = 1'b0;
    underrun_cnt_d = underrun_cnt_q;

    if (accept) begin
      hold_d = sample_i;
      full_d = 1'b1;
    end

    if (boundary) begin
      if (full_q) begin
        audio_d = hold_q;
        full_d  = 1'b0;
      end else begin
        if (MUTE_ON_UNDERRUN) audio_d = '0;
        ur_d           = 1'b1;
        underrun_cnt_d = sat_inc(underrun_cnt_q);
      end
    end

    // Drops on the accepting edge, rises one clk after a drain, so ready is
    // never high while the holding register is full.
    ready_d = ~full_q & ~accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q         <= 1'b0;
      ready_q        <= 1'b1;
      audio_q        <= '0;
      fs_q           <= 1'b0;
      ur_q           <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      full_q         <= full_d;
      ready_q        <= ready_d;
      audio_q        <= audio_d;
      fs_q           <= fs_d;
      ur_q           <= ur_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  // Holding data is qualified by full_q, so it needs no reset.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  assign sample_ready_o = ready_q;
  assign i2s_sclk       = sclk;
  assign i2s_lrclk      = lrclk;
  assign audio_o        = audio_q;
  assign frame_start_o  = fs_q;
  assign underrun_o     = ur_q;
  assign underrun_count = underrun_cnt_q;

endmodule

// File: tb/tb_i2s_frame_master.sv
// Directed bench for i2s_frame_master: BITS=16, CHANNELS=2, SCLK_DIV=4,
// FRAME_BITS=64 (frame = 512 clk). Two instances share all inputs; dut keeps
// the last frame on underrun, dut_m mutes.
module tb_i2s_frame_master;

  localparam int unsigned BITS       = 16;
  localparam int unsigned CHANNELS   = 2;
  localparam int unsigned SCLK_DIV   = 4;
  localparam int unsigned FRAME_BITS = 64;
  localparam int unsigned W          = CHANNELS * BITS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic         sample_valid_i = 1'b0;
  logic [W-1:0] sample_i = '0;

  logic         sample_ready_o, i2s_sclk, i2s_lrclk, frame_start_o, underrun_o;
  logic [W-1:0] audio_o;
  logic [15:0]  underrun_count;

  logic         ready_m, sclk_m, lrclk_m, fs_m, ur_m;
  logic [W-1:0] audio_m;
  logic [15:0]  cnt_m;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  i2s_frame_master #(
    .BITS(BITS), .CHANNELS(CHANNELS), .SCLK_DIV(SCLK_DIV),
    .FRAME_BITS(FRAME_BITS), .MUTE_ON_UNDERRUN(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .sample_i(sample_i), .sample_valid_i(sample_valid_i),
    .sample_ready_o(sample_ready_o), .i2s_sclk(i2s_sclk), .i2s_lrclk(i2s_lrclk),
    .audio_o(audio_o), .frame_start_o(frame_start_o), .underrun_o(underrun_o),
    .underrun_count(underrun_count)
  );

  i2s_frame_master #(
    .BITS(BITS), .CHANNELS(CHANNELS), .SCLK_DIV(SCLK_DIV),
    .FRAME_BITS(FRAME_BITS), .MUTE_ON_UNDERRUN(1'b1)
  ) dut_m (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .sample_i(sample_i), .sample_valid_i(sample_valid_i),
    .sample_ready_o(ready_m), .i2s_sclk(sclk_m), .i2s_lrclk(lrclk_m),
    .audio_o(audio_m), .frame_start_o(fs_m), .underrun_o(ur_m),
    .underrun_count(cnt_m)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance negedge by negedge until frame_start_o is seen or the budget runs out.
  task automatic wait_fs(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start_o && n < budget);
  endtask

  initial begin
    int n, hi, fsn, rises, nfs, cyc, bad;
    logic prev;
    logic [W-1:0] exp_v, last_audio;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_sclk", i2s_sclk, 0);
    chk("rst_lrclk", i2s_lrclk, 0);
    chk("rst_audio", audio_o, 0);
    chk("rst_fs", frame_start_o, 0);
    chk("rst_ur", underrun_o, 0);
    chk("rst_cnt", underrun_count, 0);
    chk("rst_ready", sample_ready_o, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_sclk", i2s_sclk, 0);

    // First sample accepted while idle
    sample_i = 32'h1234_ABCD;
    sample_valid_i = 1'b1;
    @(negedge clk);
    sample_valid_i = 1'b0;
    chk("accept_ready_drop", sample_ready_o, 0);
    chk("accept_audio_hold", audio_o, 0);

    // Enable: first rising toggle is a frame boundary
    enable = 1'b1;
    wait_fs(20, n);
    chk("en_to_fs_clk", n, SCLK_DIV);
    chk("fs1_pulse", frame_start_o, 1);
    chk("fs1_lrclk", i2s_lrclk, 1);
    chk("fs1_sclk", i2s_sclk, 1);
    chk("fs1_audio", audio_o, 32'h1234_ABCD);
    chk("fs1_audio_m", audio_m, 32'h1234_ABCD);
    chk("fs1_ur", underrun_o, 0);
    chk("fs1_ready", sample_ready_o, 0);

    // One full frame: SCLK/LRCLK shape and frame period
    hi = 0; fsn = 0; rises = 0; prev = i2s_sclk;
    for (int i = 0; i < 512; i++) begin
      if (i2s_lrclk) hi++;
      if (frame_start_o) fsn++;
      if (i == 1) chk("ready_after_drain", sample_ready_o, 1);
      @(negedge clk);
      if (i2s_sclk && !prev) rises++;
      prev = i2s_sclk;
    end
    chk("lrclk_high_clk", hi, 8);
    chk("fs_per_frame", fsn, 1);
    chk("sclk_rises_per_frame", rises, FRAME_BITS);
    chk("fs2_period", frame_start_o, 1);

    // Second boundary with nothing held: underrun
    chk("ur1_pulse", underrun_o, 1);
    chk("ur1_cnt", underrun_count, 1);
    chk("ur1_audio_repeat", audio_o, 32'h1234_ABCD);
    chk("ur1_audio_mute", audio_m, 0);
    chk("ur1_cnt_m", cnt_m, 1);
    @(negedge clk);
    chk("ur1_one_clk", underrun_o, 0);

    // Valid held high, data changing every clk: one sample per frame, in order
    sample_i = 32'h0001_0000;
    sample_valid_i = 1'b1;
    nfs = 0; cyc = 0;
    while (nfs < 3 && cyc < 2000) begin
      if (sample_ready_o) exp_q.push_back(sample_i);
      @(negedge clk);
      cyc++;
      sample_i = sample_i + 1'b1;
      if (frame_start_o) begin
        nfs++;
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
        chk("inc_audio", audio_o, exp_v);
        chk("inc_audio_m", audio_m, exp_v);
        chk("inc_ur", underrun_o, 0);
      end
    end
    sample_valid_i = 1'b0;
    chk("inc_frames", nfs, 3);
    chk("inc_leftover", exp_q.size(), 0);
    chk("inc_cnt", underrun_count, 1);
    last_audio = audio_o;

    // Enable dropped mid-frame with a sample held
    repeat (50) @(negedge clk);
    chk("dis_pre_ready", sample_ready_o, 1);
    sample_i = 32'hCAFE_0001;
    sample_valid_i = 1'b1;
    @(negedge clk);
    sample_valid_i = 1'b0;
    chk("dis_loaded", sample_ready_o, 0);
    repeat (100) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_sclk", i2s_sclk, 0);
    chk("dis_lrclk", i2s_lrclk, 0);
    bad = 0;
    repeat (99) begin
      @(negedge clk);
      if (i2s_sclk || i2s_lrclk || frame_start_o) bad++;
    end
    chk("dis_quiet", bad, 0);
    chk("dis_audio_kept", audio_o, last_audio);
    chk("dis_hold_kept", sample_ready_o, 0);
    enable = 1'b1;
    wait_fs(20, n);
    chk("reen_to_fs_clk", n, SCLK_DIV);
    chk("reen_audio", audio_o, 32'hCAFE_0001);
    chk("reen_ur", underrun_o, 0);
    chk("reen_cnt", underrun_count, 1);

    // Saturation: preload the counter near full, then underrun repeatedly
    repeat (10) @(negedge clk);
    force dut.underrun_cnt_q = 16'hFFFD;
    @(negedge clk);
    release dut.underrun_cnt_q;
    chk("sat_preload", underrun_count, 16'hFFFD);
    wait_fs(600, n);
    chk("sat_fs_a", frame_start_o, 1);
    chk("sat_cnt_a", underrun_count, 16'hFFFE);
    wait_fs(600, n);
    chk("sat_cnt_b", underrun_count, 16'hFFFF);
    wait_fs(600, n);
    chk("sat_fs_c", frame_start_o, 1);
    chk("sat_ur_c", underrun_o, 1);
    chk("sat_cnt_c", underrun_count, 16'hFFFF);
    chk("sat_audio_c", audio_o, 32'hCAFE_0001);

    // Asynchronous reset mid-frame
    repeat (100) @(negedge clk);
    sample_i = 32'h5555_AAAA;
    sample_valid_i = 1'b1;
    @(negedge clk);
    sample_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sclk", i2s_sclk, 0);
    chk("arst_lrclk", i2s_lrclk, 0);
    chk("arst_audio", audio_o, 0);
    chk("arst_fs", frame_start_o, 0);
    chk("arst_ur", underrun_o, 0);
    chk("arst_cnt", underrun_count, 0);
    chk("arst_ready", sample_ready_o, 1);
    chk("arst_cnt_m", cnt_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_fs(20, n);
    chk("post_rst_fs_clk", n, SCLK_DIV);
    chk("post_rst_audio", audio_o, 0);
    chk("post_rst_ur", underrun_o, 1);
    chk("post_rst_cnt", underrun_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
